clk_ratio_monitor: RTL and testbench
====================================

# clk_ratio_monitor

Measures an incoming divided clock against the reference clock and reports its period, high time and low time, in reference cycles. It is the checking end of the clock divider in the multi-clock system: it samples the divider output as data in the `i_ref_clk` domain. Each completed period is compared against the programmed division ratio. It flags mismatches and stalled clocks for the system controller.

## Interface
- `RATIO_WIDTH`, default 8: width of the ratio, count and expected-ratio fields. The maximum measurable period is 2^RATIO_WIDTH-1 cycles.
- `i_ref_clk`  in  1: reference clock. All logic is on the rising edge.
- `i_rst`  in  1: reset, asynchronous, active-high.
- `i_en`  in  1: monitor enable.
- `i_meas_clk`  in  1: clock under measurement, treated as asynchronous data.
- `i_exp_ratio`  in  RATIO_WIDTH: expected division ratio. A value of 0 or 1 disables comparison.
- `o_ratio`  out  RATIO_WIDTH: last measured period, in ref cycles.
- `o_high_cnt`  out  RATIO_WIDTH: last measured high time.
- `o_low_cnt`  out  RATIO_WIDTH: last measured low time.
- `o_valid`  out  1: one-cycle pulse when the three count outputs update.
- `o_mismatch`  out  1: the last measured period differs from `i_exp_ratio`.
- `o_stuck`  out  1: no rising edge was seen within 2^RATIO_WIDTH-1 cycles.

## Operation
- **Synchronizer:** two flops, `s1` then `s2`, plus a delayed copy `d` of `s2`.
  - `rise = s2 & ~d`
  - `fall = ~s2 & d`
- **Period counter `p_cnt`** (RATIO_WIDTH bits):
  - Loads 1 on a rise and on entering ARM.
  - Otherwise increments by 1.
  - Never wraps.
- **Timeout:** if `p_cnt` equals 2^RATIO_WIDTH-1 and there is no rise this cycle, then on the next edge:
  - `o_stuck` is set to 1.
  - The FSM moves to ARM.
  - No `o_valid` is issued.
- **Fall capture:** on a fall, `p_cnt` is held in an internal register `h_cap` as the high time.
- **States:**
  - IDLE, the reset state:
    - Counters are cleared and `o_valid` is 0.
    - The ratio, count, mismatch and stuck outputs hold their values.
    - If `i_en` is 1, go to ARM.
  - ARM:
    - Waits for the first rise. The partial period before it is discarded.
    - On a rise: `p_cnt` loads 1, go to MEASURE, no `o_valid`.
    - On timeout: set `o_stuck`, stay in ARM.
  - MEASURE, on each rise:
    - `o_ratio` takes `p_cnt`.
    - `o_high_cnt` takes `h_cap`.
    - `o_low_cnt` takes `p_cnt - h_cap`.
    - `o_valid` is 1 for one cycle.
    - `o_stuck` is cleared.
    - `o_mismatch` takes `(i_exp_ratio >= 2) && (p_cnt != i_exp_ratio)`.
    - `p_cnt` loads 1.
  - Any state with `i_en` at 0: go to IDLE on the next edge, overriding every other transition.
- **Interaction with the divider:** ratios 0 and 1 route `i_ref_clk` straight through the divider and cannot be measured. In that case:
  - `o_mismatch` is held at 0.
  - `o_stuck` and `o_ratio` behave as the samples dictate.

## Timing
- **Reset:** all outputs are 0, the FSM is in IDLE, and `s1`, `s2` and `d` are 0.
- **Latency:** `i_meas_clk` is first sampled high at ref edge k. `rise` is then combinationally true between edges k+1 and k+2. `o_valid` and the new counts are visible after edge k+2.
- **Registered outputs:** `o_valid`, `o_ratio`, `o_high_cnt`, `o_low_cnt`, `o_mismatch` and `o_stuck` all change together on the same edge.
- **Count arithmetic:** with rises at cycles 0 and N, the captured period is exactly N. With a fall at cycle H, the high time is H and the low time is N-H.
- **Simultaneous timeout and rise:** the rise wins and the period is captured as 2^RATIO_WIDTH-1.
- **`i_exp_ratio` changes mid-period:** the compare uses the value present in the capture cycle.
- **Reset mid-period:** all outputs clear immediately, asynchronously. After reset release, the first `o_valid` needs one full period after ARM.
- **`i_en` deasserted in the capture cycle:**
  - The capture still occurs on that edge.
  - The FSM is in IDLE after it.
  - No further `o_valid` pulses are issued.

## Test plan
- **Divide-by-8:** drive `i_meas_clk` from the divider at ratio 8 with `i_exp_ratio` = 8 and `i_en` = 1. Required response: the first `o_valid` falls on the second rise after ARM, with `o_ratio` = 8, `o_high_cnt` = 4, `o_low_cnt` = 4, `o_mismatch` = 0. `o_valid` then repeats every 8 cycles.
- **Odd ratio 5:** required response: `o_ratio` = 5, `o_high_cnt` = 2, `o_low_cnt` = 3, `o_mismatch` = 0.
- **Ratio mismatch:** measured ratio 8 with `i_exp_ratio` = 6. Required response: `o_mismatch` = 1 on every `o_valid`. Changing `i_exp_ratio` to 0 gives `o_mismatch` = 0 on the next `o_valid`.
- **Stalled clock:** hold `i_meas_clk` low for 300 cycles mid-MEASURE. Required response:
  - `o_stuck` = 1 exactly 255 cycles after the last rise's load, with no `o_valid`.
  - After resuming at ratio 4, the second rise gives `o_valid` with `o_ratio` = 4 and `o_stuck` = 0.
- **Enable drop:** drop `i_en` at cycle 3 of a period, then raise it again after 20 cycles. Required response:
  - No `o_valid` while disabled, and outputs hold their last values.
  - On re-enable, the first partial period is discarded before a correct capture.
- **Async reset:** assert `i_rst` between edges mid-period. Required response: all outputs are 0 before the next edge. After release, the behaviour matches the divide-by-8 scenario.

Source files
------------

// File: rtl/clk_ratio_monitor.sv
// Clock ratio monitor: measures period, high and low time of a divided clock in
// reference cycles, checks the period against the programmed ratio and flags stalls.
module clk_ratio_monitor #(
    parameter int unsigned RATIO_WIDTH = 8
) (
    input  logic                   i_ref_clk,
    input  logic                   i_rst,
    input  logic                   i_en,
    input  logic                   i_meas_clk,
    input  logic [RATIO_WIDTH-1:0] i_exp_ratio,
    output logic [RATIO_WIDTH-1:0] o_ratio,
    output logic [RATIO_WIDTH-1:0] o_high_cnt,
    output logic [RATIO_WIDTH-1:0] o_low_cnt,
    output logic                   o_valid,
    output logic                   o_mismatch,
    output logic                   o_stuck
);

    localparam logic [RATIO_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [RATIO_WIDTH-1:0] CNT_ONE = RATIO_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic                   s1;
    logic                   s2;
    logic                   d;
    logic                   rise;
    logic                   fall;
    logic                   timeout;
    logic                   capture;
    logic                   stall;
    logic [RATIO_WIDTH-1:0] p_cnt;
    logic [RATIO_WIDTH-1:0] h_cap;

    always_ff @(posedge i_ref_clk or posedge i_rst) begin
        if (i_rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            d  <= 1'b0;
        end else begin
            s1 <= i_meas_clk;
            s2 <= s1;
            d  <= s2;
        end
    end

    always_ff @(posedge i_ref_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        stall      = 1'b0;
        rise       = s2 & ~d;
        fall       = ~s2 & d;
        // A rise in the same cycle as the count limit wins over the timeout.
        timeout    = (p_cnt == CNT_MAX) && !rise;
        case (state)
            IDLE: begin
                if (i_en) begin
                    state_next = ARM;
                end
            end
            ARM: begin
                if (rise) begin
                    state_next = MEASURE;
                end else if (timeout) begin
                    stall = 1'b1;
                end
            end
            MEASURE: begin
                if (rise) begin
                    capture = 1'b1;
                end else if (timeout) begin
                    stall      = 1'b1;
                    state_next = ARM;
                end
            end
            default: state_next = IDLE;
        endcase
        if (!i_en) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge i_ref_clk or posedge i_rst) begin
        if (i_rst) begin
            p_cnt <= '0;
            h_cap <= '0;
        end else if (state == IDLE) begin
            p_cnt <= i_en ? CNT_ONE : '0;
            h_cap <= '0;
        end else begin
            if (rise || stall) begin
                p_cnt <= CNT_ONE;
            end else if (p_cnt != CNT_MAX) begin
                p_cnt <= p_cnt + CNT_ONE;
            end
            if (fall) begin
                h_cap <= p_cnt;
            end
        end
    end

    always_ff @(posedge i_ref_clk or posedge i_rst) begin
        if (i_rst) begin
            o_ratio    <= '0;
            o_high_cnt <= '0;
            o_low_cnt  <= '0;
            o_valid    <= 1'b0;
            o_mismatch <= 1'b0;
            o_stuck    <= 1'b0;
        end else begin
            o_valid <= capture;
            if (capture) begin
                o_ratio    <= p_cnt;
                o_high_cnt <= h_cap;
                o_low_cnt  <= p_cnt - h_cap;
                o_stuck    <= 1'b0;
                o_mismatch <= (i_exp_ratio > CNT_ONE) && (p_cnt != i_exp_ratio);
            end else if (stall) begin
                o_stuck <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_clk_ratio_monitor.sv
// Scoreboard bench for clk_ratio_monitor: directed waveforms push expected
// capture records; a negedge monitor pops and compares on every o_valid.
module tb_clk_ratio_monitor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         meas;
    logic [W-1:0] exp_ratio;
    logic [W-1:0] ratio;
    logic [W-1:0] high_cnt;
    logic [W-1:0] low_cnt;
    logic         valid;
    logic         mismatch;
    logic         stuck;

    typedef struct {
        int ratio;
        int high;
        int low;
        int mm;
        int stuck;
        int gap;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   mon_gap;
    int   checks     = 0;
    int   errors     = 0;
    int   cyc        = 0;
    int   last_valid = 0;
    int   stuck_seen;
    int   stuck_cyc;

    clk_ratio_monitor #(.RATIO_WIDTH(W)) dut (
        .i_ref_clk   (clk),
        .i_rst       (rst),
        .i_en        (en),
        .i_meas_clk  (meas),
        .i_exp_ratio (exp_ratio),
        .o_ratio     (ratio),
        .o_high_cnt  (high_cnt),
        .o_low_cnt   (low_cnt),
        .o_valid     (valid),
        .o_mismatch  (mismatch),
        .o_stuck     (stuck)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            checks++;
            mon_gap = cyc - last_valid;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid cyc=%0d actual ratio=%0d high=%0d low=%0d required no valid",
                         cyc, ratio, high_cnt, low_cnt);
            end else begin
                mon_e = q.pop_front();
                if (int'(ratio) != mon_e.ratio || int'(high_cnt) != mon_e.high ||
                    int'(low_cnt) != mon_e.low || int'(mismatch) != mon_e.mm ||
                    int'(stuck) != mon_e.stuck || (mon_e.gap != 0 && mon_gap != mon_e.gap)) begin
                    errors++;
                    $display("FAIL valid_record cyc=%0d actual ratio=%0d high=%0d low=%0d mismatch=%0d stuck=%0d gap=%0d required ratio=%0d high=%0d low=%0d mismatch=%0d stuck=%0d gap=%0d",
                             cyc, ratio, high_cnt, low_cnt, mismatch, stuck, mon_gap,
                             mon_e.ratio, mon_e.high, mon_e.low, mon_e.mm, mon_e.stuck, mon_e.gap);
                end
            end
            last_valid = cyc;
        end
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic expect_v(input int r, input int h, input int l, input int mm,
                            input int st, input int gap);
        exp_t e;
        e.ratio = r;
        e.high  = h;
        e.low   = l;
        e.mm    = mm;
        e.stuck = st;
        e.gap   = gap;
        q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic periods(input int n, input int h, input int l);
        for (int i = 0; i < n; i++) begin
            meas = 1'b1;
            tick(h);
            meas = 1'b0;
            tick(l);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ratio"},    int'(ratio),    0);
        check({tag, "_high"},     int'(high_cnt), 0);
        check({tag, "_low"},      int'(low_cnt),  0);
        check({tag, "_valid"},    int'(valid),    0);
        check({tag, "_mismatch"}, int'(mismatch), 0);
        check({tag, "_stuck"},    int'(stuck),    0);
    endtask

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        meas      = 1'b0;
        exp_ratio = '0;
        tick(3);
        check_all_zero("reset");

        // Divide-by-8: first rise after ARM is discarded
        rst       = 1'b0;
        en        = 1'b1;
        exp_ratio = 8'd8;
        tick(3);
        expect_v(8, 4, 4, 0, 0, 0);
        expect_v(8, 4, 4, 0, 0, 8);
        expect_v(8, 4, 4, 0, 0, 8);
        periods(4, 4, 4);

        // Odd ratio 5; first capture closes the last 8-cycle period against exp 5
        exp_ratio = 8'd5;
        expect_v(8, 4, 4, 1, 0, 8);
        repeat (3) expect_v(5, 2, 3, 0, 0, 5);
        periods(4, 2, 3);

        // Mismatch against 6, then comparison disabled with 0
        exp_ratio = 8'd6;
        expect_v(5, 2, 3, 1, 0, 5);
        repeat (3) expect_v(8, 4, 4, 1, 0, 8);
        periods(4, 4, 4);
        exp_ratio = 8'd0;
        expect_v(8, 4, 4, 0, 0, 8);
        expect_v(8, 4, 4, 0, 0, 8);
        periods(2, 4, 4);

        // Stalled clock held low for 300 cycles
        stuck_seen = 0;
        stuck_cyc  = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (stuck === 1'b1 && stuck_seen == 0) begin
                stuck_seen = 1;
                stuck_cyc  = cyc;
            end
        end
        check("stuck_seen", stuck_seen, 1);
        check("stuck_delay", stuck_cyc - last_valid, 255);
        check("stuck_hold_ratio", int'(ratio), 8);
        tick(1);

        // Resume at ratio 4 from ARM
        exp_ratio = 8'd4;
        expect_v(4, 2, 2, 0, 0, 0);
        expect_v(4, 2, 2, 0, 0, 4);
        periods(3, 2, 2);

        // Enable drop at cycle 3 of a period, ~21 cycles disabled
        exp_ratio = 8'd8;
        expect_v(4, 2, 2, 1, 0, 4);
        expect_v(8, 4, 4, 0, 0, 8);
        periods(2, 4, 4);
        expect_v(8, 4, 4, 0, 0, 8);
        meas = 1'b1;
        tick(3);
        en = 1'b0;
        tick(1);
        meas = 1'b0;
        tick(4);
        periods(2, 4, 4);
        check("hold_ratio",    int'(ratio),    8);
        check("hold_high",     int'(high_cnt), 4);
        check("hold_low",      int'(low_cnt),  4);
        check("hold_mismatch", int'(mismatch), 0);
        check("hold_stuck",    int'(stuck),    0);
        check("hold_valid",    int'(valid),    0);
        en = 1'b1;
        tick(2);
        expect_v(8, 4, 4, 0, 0, 0);
        expect_v(8, 4, 4, 0, 0, 8);
        periods(3, 4, 4);

        // Asynchronous reset between edges, mid-period
        expect_v(8, 4, 4, 0, 0, 8);
        meas = 1'b1;
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_all_zero("async_reset");
        tick(2);
        meas = 1'b0;
        rst  = 1'b0;
        tick(2);
        expect_v(8, 4, 4, 0, 0, 0);
        expect_v(8, 4, 4, 0, 0, 8);
        expect_v(8, 4, 4, 0, 0, 8);
        periods(4, 4, 4);

        tick(5);
        check("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
